// File: rtl/xtea_word_bridge.sv
// Word-serial front end for the 128-bit XTEA core: packs 32-bit key/data words into
// the core's registers, launches one operation, and streams the result back out.
module xtea_word_bridge #(
  parameter int WORD_SIZE = 128,
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] s_data,
  input  logic                 s_is_key,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 cfg_enc_dec,
  output logic [BUS_WIDTH-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic [WORD_SIZE-1:0] x_data_in,
  output logic [WORD_SIZE-1:0] x_key,
  output logic                 x_start,
  output logic                 x_enc_dec,
  input  logic                 x_ready,
  input  logic [WORD_SIZE-1:0] x_data_out,
  output logic                 busy,
  output logic [15:0]          blk_count
);

  localparam logic [2:0] FILL    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;

  logic [2:0]           state;
  logic [1:0]           dcnt;
  logic [1:0]           ocnt;
  logic [WORD_SIZE-1:0] obuf;

  // Every handshake output is a pure decode of the state, so none needs its own flop.
  assign s_ready = (state == FILL);
  assign x_start = (state == START);
  assign m_valid = (state == DRAIN);
  assign busy    = (state != FILL);
  assign m_last  = m_valid && (ocnt == 2'd3);
  assign m_data  = obuf[WORD_SIZE-1 -: BUS_WIDTH];

  // NOTE: all state below uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would let later statements see half-updated state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      dcnt      <= 2'd0;
      ocnt      <= 2'd0;
      x_key     <= '0;
      x_data_in <= '0;
      x_enc_dec <= 1'b0;
      // NOTE: obuf is a datapath register but drives m_data directly, so it is reset
      // to give m_data a defined value; datapath regs without visible outputs need not be.
      obuf      <= '0;
      blk_count <= 16'd0;
    end else begin
      case (state)
        FILL: begin
          if (s_valid) begin
            if (s_is_key) begin
              x_key <= {x_key[WORD_SIZE-BUS_WIDTH-1:0], s_data};
            end else begin
              x_data_in <= {x_data_in[WORD_SIZE-BUS_WIDTH-1:0], s_data};
              dcnt      <= dcnt + 2'd1;
              if (dcnt == 2'd3) begin
                x_enc_dec <= cfg_enc_dec;
                state     <= START;
              end
            end
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (x_ready) state <= CAPTURE;
        end
        CAPTURE: begin
          // The core's data_out settles on the edge that ends its ready cycle.
          obuf  <= x_data_out;
          state <= DRAIN;
        end
        DRAIN: begin
          if (m_ready) begin
            obuf <= {obuf[WORD_SIZE-BUS_WIDTH-1:0], {BUS_WIDTH{1'b0}}};
            ocnt <= ocnt + 2'd1;
            if (ocnt == 2'd3) begin
              blk_count <= blk_count + 16'd1;
              state     <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
